// File: rtl/mcdf_pkg.sv
// Shared constants and helpers for the multi-channel data formatter.
// Each channel ingress stage imports this package.
package mcdf_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned DEPTH    = 32;
    localparam int unsigned SLOT_W   = 6;
    localparam int unsigned CHNL_NUM = 4;

    // Returns the parity bit that makes the word plus parity bit even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with an occupancy count.
// Push is ignored when full and pop is ignored when empty.
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push    = push_i & ~full_o;
    assign pop     = pop_i & ~empty_o;
    assign data_o  = mem[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/chnl_slave.sv
// Per-channel ingress stage: parity check, sticky error, ready gating,
// buffering in a show-ahead FIFO and packet-ready request.
module chnl_slave
    import mcdf_pkg::*;
#(
    parameter int unsigned DATA_W = mcdf_pkg::DATA_W,
    parameter int unsigned DEPTH  = mcdf_pkg::DEPTH,
    parameter int unsigned SLOT_W = mcdf_pkg::SLOT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              slv_en_i,
    input  logic              err_clr_i,
    input  logic [7:0]        slv_len_i,
    input  logic [DATA_W-1:0] chnl_data_i,
    input  logic              chnl_parity_i,
    input  logic              chnl_valid_i,
    output logic              chnl_ready_o,
    output logic [DATA_W-1:0] slv_data_o,
    output logic              slv_val_o,
    input  logic              slv_rdy_i,
    output logic              slv_req_o,
    output logic [SLOT_W-1:0] slv_free_slot_o,
    output logic              slv_parity_err_o
);

    logic              err_q, err_d;
    logic              full, empty;
    logic [SLOT_W-1:0] count;
    logic              accept, parity_ok, push;
    logic [8:0]        len_p1, req_thr;

    assign chnl_ready_o = slv_en_i & ~full & ~err_q;
    assign accept       = chnl_valid_i & chnl_ready_o;
    assign parity_ok    = (even_parity(chnl_data_i) == chnl_parity_i);
    assign push         = accept & parity_ok;

    always_comb begin
        err_d = err_q;
        if (accept & ~parity_ok) err_d = 1'b1;
        else if (err_clr_i)      err_d = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (SLOT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (chnl_data_i),
        .pop_i   (slv_rdy_i),
        .data_o  (slv_data_o),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Threshold is formed at 9 bits so a length of 255 does not wrap to 0.
    assign len_p1  = {1'b0, slv_len_i} + 9'd1;
    assign req_thr = (len_p1 > 9'(DEPTH)) ? 9'(DEPTH) : len_p1;

    assign slv_req_o        = (9'(count) >= req_thr);
    assign slv_val_o        = ~empty;
    assign slv_free_slot_o  = SLOT_W'(DEPTH) - count;
    assign slv_parity_err_o = err_q;

endmodule

// File: tb/tb_chnl_slave.sv
// Directed bench for chnl_slave: a queue model is checked every cycle,
// with hand-computed literal expectations at key points.
module tb_chnl_slave;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        slv_en_i;
    logic        err_clr_i;
    logic [7:0]  slv_len_i;
    logic [31:0] chnl_data_i;
    logic        chnl_parity_i;
    logic        chnl_valid_i;
    logic        chnl_ready_o;
    logic [31:0] slv_data_o;
    logic        slv_val_o;
    logic        slv_rdy_i;
    logic        slv_req_o;
    logic [5:0]  slv_free_slot_o;
    logic        slv_parity_err_o;

    int checks   = 0;
    int failures = 0;

    int unsigned mq[$];
    bit          m_err;

    always #5 clk_i = ~clk_i;

    chnl_slave #(.DATA_W(32), .DEPTH(32), .SLOT_W(6)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .slv_en_i         (slv_en_i),
        .err_clr_i        (err_clr_i),
        .slv_len_i        (slv_len_i),
        .chnl_data_i      (chnl_data_i),
        .chnl_parity_i    (chnl_parity_i),
        .chnl_valid_i     (chnl_valid_i),
        .chnl_ready_o     (chnl_ready_o),
        .slv_data_o       (slv_data_o),
        .slv_val_o        (slv_val_o),
        .slv_rdy_i        (slv_rdy_i),
        .slv_req_o        (slv_req_o),
        .slv_free_slot_o  (slv_free_slot_o),
        .slv_parity_err_o (slv_parity_err_o)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return slv_en_i && (mq.size() < 32) && !m_err;
    endfunction

    function automatic bit m_req();
        int thr;
        thr = int'(slv_len_i) + 1;
        if (thr > 32) thr = 32;
        return int'(mq.size()) >= thr;
    endfunction

    // Model advance for one clock edge, using the inputs held across it.
    task automatic model_update();
        bit acc, good, pop;
        if (rst_i) begin
            mq.delete();
            m_err = 1'b0;
            return;
        end
        acc  = chnl_valid_i && m_ready();
        good = ((^chnl_data_i) == chnl_parity_i);
        pop  = (mq.size() > 0) && slv_rdy_i;
        if (pop) void'(mq.pop_front());
        if (acc && good) mq.push_back(chnl_data_i);
        if (acc && !good)   m_err = 1'b1;
        else if (err_clr_i) m_err = 1'b0;
    endtask

    task automatic compare_all();
        chk("val", {31'b0, slv_val_o}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) chk("data", slv_data_o, mq[0]);
        chk("free", {26'b0, slv_free_slot_o}, 32 - mq.size());
        chk("req", {31'b0, slv_req_o}, {31'b0, m_req()});
        chk("perr", {31'b0, slv_parity_err_o}, {31'b0, m_err});
        chk("ready", {31'b0, chnl_ready_o}, {31'b0, m_ready()});
    endtask

    task automatic cycle();
        @(posedge clk_i);
        model_update();
        @(negedge clk_i);
        compare_all();
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit r);
        chnl_valid_i  = v;
        chnl_data_i   = d;
        chnl_parity_i = ^d;
        slv_rdy_i     = r;
        cycle();
    endtask

    task automatic drain();
        int n;
        n = mq.size();
        for (int i = 0; i < n; i++) step(0, 32'h0, 1);
        chk("drained", {26'b0, slv_free_slot_o}, 32'd32);
    endtask

    initial begin
        rst_i = 1'b1; slv_en_i = 1'b0; err_clr_i = 1'b0; slv_len_i = 8'd0;
        chnl_data_i = '0; chnl_parity_i = 1'b0; chnl_valid_i = 1'b0; slv_rdy_i = 1'b0;
        m_err = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_val", {31'b0, slv_val_o}, 32'd0);
        chk("rst_free", {26'b0, slv_free_slot_o}, 32'd32);
        chk("rst_req", {31'b0, slv_req_o}, 32'd0);
        chk("rst_perr", {31'b0, slv_parity_err_o}, 32'd0);
        chk("rst_ready", {31'b0, chnl_ready_o}, 32'd0);
        rst_i = 1'b0;
        slv_en_i = 1'b1;

        // Three words held, then drained in order.
        step(1, 32'h11, 0);
        chk("free31", {26'b0, slv_free_slot_o}, 32'd31);
        step(1, 32'h22, 0);
        step(1, 32'h33, 0);
        chk("free29", {26'b0, slv_free_slot_o}, 32'd29);
        chk("head11", slv_data_o, 32'h11);
        chk("val3", {31'b0, slv_val_o}, 32'd1);
        chnl_valid_i = 1'b0;
        chk("out0", slv_data_o, 32'h11); step(0, 0, 1);
        chk("out1", slv_data_o, 32'h22); step(0, 0, 1);
        chk("out2", slv_data_o, 32'h33); step(0, 0, 1);
        chk("free32", {26'b0, slv_free_slot_o}, 32'd32);
        chk("empty", {31'b0, slv_val_o}, 32'd0);

        // Fill to full; a pop while full does not open ready that cycle.
        for (int i = 0; i < 32; i++) step(1, 32'h100 + i, 0);
        chk("full_ready", {31'b0, chnl_ready_o}, 32'd0);
        chk("full_free", {26'b0, slv_free_slot_o}, 32'd0);
        step(1, 32'h999, 1);
        chk("after_pop_ready", {31'b0, chnl_ready_o}, 32'd1);
        chk("after_pop_head", slv_data_o, 32'h101);
        for (int i = 0; i < 40; i++) step(1, 32'h200 + i, 1);
        drain();

        // Bad parity: dropped, error sticks until cleared.
        chnl_valid_i = 1'b1; chnl_data_i = 32'h1; chnl_parity_i = 1'b0; slv_rdy_i = 1'b0;
        cycle();
        chk("perr_set", {31'b0, slv_parity_err_o}, 32'd1);
        chk("perr_ready", {31'b0, chnl_ready_o}, 32'd0);
        chk("perr_nostore", {31'b0, slv_val_o}, 32'd0);
        step(1, 32'h5, 0);
        chk("perr_stall", {26'b0, slv_free_slot_o}, 32'd32);
        err_clr_i = 1'b1;
        step(0, 0, 0);
        err_clr_i = 1'b0;
        chk("perr_clr", {31'b0, slv_parity_err_o}, 32'd0);
        chk("clr_ready", {31'b0, chnl_ready_o}, 32'd1);

        // Request threshold.
        slv_len_i = 8'd3;
        for (int i = 0; i < 3; i++) step(1, 32'hA0 + i, 0);
        chk("req3", {31'b0, slv_req_o}, 32'd0);
        step(1, 32'hA3, 0);
        chk("req4", {31'b0, slv_req_o}, 32'd1);
        slv_len_i = 8'd255;
        for (int i = 0; i < 27; i++) step(1, 32'hB0 + i, 0);
        chk("req255_31", {31'b0, slv_req_o}, 32'd0);
        step(1, 32'hCC, 0);
        chk("req255_32", {31'b0, slv_req_o}, 32'd1);
        slv_len_i = 8'd0;
        drain();

        // Simultaneous push and pop at occupancy 10.
        for (int i = 0; i < 10; i++) step(1, 32'hD00 + i, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 32'hE00 + i, 1);
            chk("steady_free", {26'b0, slv_free_slot_o}, 32'd22);
        end
        chk("steady_head", slv_data_o, 32'hE0A);
        drain();

        // Disable mid-stream, then asynchronous reset mid-drain.
        for (int i = 0; i < 5; i++) step(1, 32'hF0 + i, 0);
        slv_en_i = 1'b0;
        #1;
        chk("dis_ready", {31'b0, chnl_ready_o}, 32'd0);
        step(1, 32'h77, 1);
        step(1, 32'h78, 1);
        chk("dis_head", slv_data_o, 32'hF2);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_val", {31'b0, slv_val_o}, 32'd0);
        chk("arst_free", {26'b0, slv_free_slot_o}, 32'd32);
        mq.delete();
        m_err = 1'b0;
        step(0, 0, 0);
        rst_i = 1'b0;
        slv_en_i = 1'b1;
        step(1, 32'h1234, 0);
        step(1, 32'h5678, 0);
        chk("post_rst_head", slv_data_o, 32'h1234);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chnl_slave.md
# chnl_slave

Per-channel ingress stage of the multi-channel data formatter. It accepts 32-bit words with a parity bit from one external channel, checks parity, and buffers good words in a FIFO. Buffered words are offered to the downstream arbiter/formatter. One instance per channel (four total). Each instance takes its enable, error-clear and packet length from the register block, and returns its free-slot count and sticky parity error to that block.

## Interface
- `DATA_W`, 32, data word width
- `DEPTH`, 32, FIFO depth in words; power of two, ≤ 32
- `SLOT_W`, 6, width of free-slot count; holds 0..DEPTH
- `clk_i` in 1: single clock
- `rst_i` in 1: reset, asynchronous, active-high
- `slv_en_i` in 1: channel enable, from register block
- `err_clr_i` in 1: clears the sticky parity error, from register block
- `slv_len_i` in 8: packet length minus one, from register block
- `chnl_data_i` in DATA_W: ingress data
- `chnl_parity_i` in 1: even parity over `chnl_data_i`
- `chnl_valid_i` in 1: ingress valid
- `chnl_ready_o` out 1: ingress ready
- `slv_data_o` out DATA_W: head-of-FIFO word
- `slv_val_o` out 1: head word valid
- `slv_rdy_i` in 1: downstream consumes the head word
- `slv_req_o` out 1: a full packet is buffered
- `slv_free_slot_o` out SLOT_W: DEPTH minus occupancy
- `slv_parity_err_o` out 1: sticky parity error

## Operation
- Ingress accept is `chnl_valid_i & chnl_ready_o`.
- `chnl_ready_o = slv_en_i & ~full & ~slv_parity_err_o`. It is combinational from registers and `slv_en_i`.
- Parity is good when `^chnl_data_i == chnl_parity_i`.
- Accepted beat with good parity: the word is pushed into the FIFO.
- Accepted beat with bad parity: the handshake completes and the word is dropped. `slv_parity_err_o` sets next cycle.
- While the parity error is set, ingress stalls (`chnl_ready_o` = 0). The FIFO keeps draining.
- `err_clr_i` high clears `slv_parity_err_o` next cycle. If a bad-parity accept occurs in the same cycle, the set wins. This cannot happen in practice, because ready is low while the error is set; the error is only set after a bad beat.
- Egress is show-ahead:
  - `slv_val_o = ~empty`.
  - `slv_data_o = mem[rd_ptr]`.
  - A pop occurs on `slv_val_o & slv_rdy_i`.
  - `slv_data_o` is don't-care while `slv_val_o` = 0.
- `slv_req_o = (count >= min(slv_len_i + 1, DEPTH))`.
  - The comparison is done at 9 bits, so `slv_len_i` = 255 does not wrap.
  - `slv_req_o` is a level. The arbiter samples it; this block does not latch it.
- Occupancy:
  - `count` is SLOT_W bits.
  - Push only: +1. Pop only: −1. Push and pop in the same cycle: unchanged.
  - `full = (count == DEPTH)`, `empty = (count == 0)`.
- Pointers are log2(DEPTH) bits and wrap naturally.
- `slv_en_i` deasserted mid-stream stops ingress only. Buffered data still drains.
- Reset values: count 0, pointers 0, `slv_val_o` 0, `slv_req_o` 0, `slv_free_slot_o` = DEPTH (32), `slv_parity_err_o` 0, `chnl_ready_o` 0 (because `slv_en_i` resets low in the register block). FIFO memory is not reset.
- Reset asserted mid-operation discards all buffered words and the error. Outputs take their reset values asynchronously.

## Timing
- Ingress to egress latency: a word accepted at edge N appears on `slv_val_o`/`slv_data_o` after edge N, i.e. visible in cycle N+1.
- `slv_free_slot_o` and `slv_req_o` reflect a push or pop from the following cycle.
- `slv_parity_err_o` rises one cycle after the bad beat. `chnl_ready_o` falls in the same cycle.
- Full: with `count` = DEPTH, `chnl_ready_o` = 0 even if a pop occurs that cycle. Ready returns the cycle after the pop. This keeps the ready path free of `slv_rdy_i`.
- Throughput: one push and one pop per cycle sustained while neither full nor empty.

## Structure
- Shared package `mcdf_pkg` holds:
  - `DATA_W`, `DEPTH`, `SLOT_W`
  - the channel count (4)
  - the parity function
- Sub-module `sync_fifo` provides memory, pointers, count and full/empty, with push/pop ports.
- `chnl_slave` holds the parity check, error flag, ready gating and request compare.

## Test plan
- Reset, then `slv_en_i` = 1. Push 3 good words 0x11, 0x22, 0x33 with `slv_rdy_i` = 0.
  - `slv_free_slot_o` steps 32→29.
  - `slv_val_o` = 1 with `slv_data_o` = 0x11.
  - After `slv_rdy_i` = 1 for 3 cycles: data comes out in order and free slot returns to 32.
- Fill to 32 words with `slv_rdy_i` = 0.
  - `chnl_ready_o` = 0 and `slv_free_slot_o` = 0.
  - One pop, then ready = 1 the next cycle.
  - Check pointer wrap over 40 more words.
- Send 0x00000001 with parity 0.
  - The word is not stored.
  - `slv_parity_err_o` = 1 next cycle and `chnl_ready_o` = 0.
  - Pulse `err_clr_i`: the error clears next cycle and ready returns.
- Set `slv_len_i` = 3 and push 3 words: `slv_req_o` = 0. The 4th word gives `slv_req_o` = 1. Set `slv_len_i` = 255 and fill: `slv_req_o` = 1 only at count 32.
- With the FIFO at 10 words, push and pop in the same cycle for 20 cycles.
  - Count stays at 10.
  - `slv_free_slot_o` stays at 22.
  - Data order is preserved.
- With 5 words buffered, drop `slv_en_i`: ready = 0 and the 5 words still drain. Assert `rst_i` mid-drain: `slv_val_o` = 0 and `slv_free_slot_o` = 32 immediately.
